outport_arbiter: RTL

OUTPORT_ARBITER -- requirements
Module: outport_arbiter

---
 rtl/outport_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/outport_arbiter.sv
// Two-requester round-robin arbiter in front of a broadcast output-port bus.
// Accepted writes produce one po_wen cycle before the completion pulse; rejects complete at once.
module outport_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          WIDTH     = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             m0_valid,
    input  logic [31:0]      m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    input  logic [3:0]       m0_wstrb,
    output logic             m0_ready,
    output logic             m0_err,
    input  logic             m1_valid,
    input  logic [31:0]      m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    input  logic [3:0]       m1_wstrb,
    output logic             m1_ready,
    output logic             m1_err,
    output logic [31:0]      po_addr,
    output logic [WIDTH-1:0] po_wdata,
    output logic             po_wen,
    output logic [1:0]       grant,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      po_addr_q, po_addr_d;
    logic [WIDTH-1:0] po_wdata_q, po_wdata_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic             rej_q, rej_d;

    logic             pick;
    logic [31:0]      sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic [3:0]       sel_wstrb;
    logic [32:0]      offset;
    logic             in_win;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        pick      = (m0_valid && m1_valid) ? ~last_q : m1_valid;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_wstrb = pick ? m1_wstrb : m0_wstrb;
        // An address below the base wraps to a huge 33-bit offset, so one compare covers both ends.
        offset    = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
        in_win    = (offset < 33'd256);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            po_addr_q  <= '0;
            po_wdata_q <= '0;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            rej_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            po_addr_q  <= po_addr_d;
            po_wdata_q <= po_wdata_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            rej_q      <= rej_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        po_addr_d  = po_addr_q;
        po_wdata_d = po_wdata_q;
        grant_d    = grant_q;
        last_d     = last_q;
        rej_d      = rej_q;
        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_d    = pick ? 2'b10 : 2'b01;
                    last_d     = pick;
                    po_addr_d  = sel_addr;
                    po_wdata_d = sel_wdata;
                    rej_d      = !((sel_wstrb != 4'b0000) && in_win);
                    state_d    = rej_d ? RESP : WRITE;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign po_addr  = po_addr_q;
    assign po_wdata = po_wdata_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign po_wen   = (state_q == WRITE);
    assign m0_ready = (state_q == RESP) && grant_q[0];
    assign m1_ready = (state_q == RESP) && grant_q[1];
    assign m0_err   = m0_ready && rej_q;
    assign m1_err   = m1_ready && rej_q;
endmodule
